// File: rtl/hazard_stall_unit_if.sv
// Signal bundle between the ID-stage hazard/stall controller and the pipeline
// registers it drives: hazard operands in, PC/IF-ID/ID-EX controls and counters out.
interface hazard_stall_unit_if #(
   parameter int REG_BITS = 5,
   parameter int CNT_W    = 32
);
   logic [REG_BITS-1:0] IF_ID_RS;
   logic [REG_BITS-1:0] IF_ID_RT;
   logic                IF_ID_USES_RT;
   logic                IF_ID_BRANCH;
   logic                ID_EX_MEMREAD;
   logic                ID_EX_REGWRITE;
   logic [REG_BITS-1:0] ID_EX_DEST;
   logic                EX_MEM_MEMREAD;
   logic [REG_BITS-1:0] EX_MEM_RD;
   logic                BRANCH_TAKEN;
   logic                PC_WRITE;
   logic                IF_ID_WRITE;
   logic                ID_EX_BUBBLE;
   logic                IF_ID_FLUSH;
   logic [CNT_W-1:0]    STALL_CYCLES;
   logic [CNT_W-1:0]    FLUSH_COUNT;

   // The pipeline side drives the operand/hazard information.
   modport master (
      output IF_ID_RS, IF_ID_RT, IF_ID_USES_RT, IF_ID_BRANCH,
             ID_EX_MEMREAD, ID_EX_REGWRITE, ID_EX_DEST,
             EX_MEM_MEMREAD, EX_MEM_RD, BRANCH_TAKEN,
      input  PC_WRITE, IF_ID_WRITE, ID_EX_BUBBLE, IF_ID_FLUSH,
             STALL_CYCLES, FLUSH_COUNT
   );

   modport slave (
      input  IF_ID_RS, IF_ID_RT, IF_ID_USES_RT, IF_ID_BRANCH,
             ID_EX_MEMREAD, ID_EX_REGWRITE, ID_EX_DEST,
             EX_MEM_MEMREAD, EX_MEM_RD, BRANCH_TAKEN,
      output PC_WRITE, IF_ID_WRITE, ID_EX_BUBBLE, IF_ID_FLUSH,
             STALL_CYCLES, FLUSH_COUNT
   );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / branch-operand hazard detector for the 5-stage MIPS pipeline.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
   parameter int REG_BITS = 5,
   parameter int CNT_W    = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   hazard_stall_unit_if.slave bus
);

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } stateT;

   stateT state_q;
   stateT state_d;

   logic [REG_BITS-1:0] idRs;
   logic [REG_BITS-1:0] idRt;
   logic [REG_BITS-1:0] exDest;
   logic [REG_BITS-1:0] memRd;

   logic depEx;
   logic depMem;
   logic needTwo;
   logic needOne;
   logic stall;
   logic flush;

   assign idRs   = bus.IF_ID_RS;
   assign idRt   = bus.IF_ID_RT;
   assign exDest = bus.ID_EX_DEST;
   assign memRd  = bus.EX_MEM_RD;

   // Register 0 is hardwired, so a write to it can never be a true dependency.
   assign depEx  = (exDest != '0) &&
                   ((exDest == idRs) || (bus.IF_ID_USES_RT && (exDest == idRt)));
   assign depMem = (memRd != '0) &&
                   ((memRd == idRs) || (bus.IF_ID_USES_RT && (memRd == idRt)));

   assign needTwo = bus.IF_ID_BRANCH && bus.ID_EX_MEMREAD && depEx;
   assign needOne = (bus.ID_EX_MEMREAD && depEx) ||
                    (bus.IF_ID_BRANCH && bus.ID_EX_REGWRITE && !bus.ID_EX_MEMREAD && depEx) ||
                    (bus.IF_ID_BRANCH && bus.EX_MEM_MEMREAD && depMem);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // A branch sitting behind a load needs two bubbles; HOLD supplies the second.
   always_comb begin
      state_d = RUN;
      stall   = 1'b0;
      flush   = 1'b0;
      if (rst_n) begin
         case (state_q)
            RUN: begin
               if (needTwo) begin
                  stall   = 1'b1;
                  state_d = HOLD;
               end else if (needOne) begin
                  stall   = 1'b1;
               end else begin
                  flush   = bus.BRANCH_TAKEN;
               end
            end
            HOLD: begin
               stall   = 1'b1;
               state_d = RUN;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   assign bus.PC_WRITE     = !stall;
   assign bus.IF_ID_WRITE  = !stall;
   assign bus.ID_EX_BUBBLE = stall;
   assign bus.IF_ID_FLUSH  = flush;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stallCnt_q;
   logic [CNT_W-1:0] stallCnt_d;
   logic [CNT_W-1:0] flushCnt_q;
   logic [CNT_W-1:0] flushCnt_d;

   always_comb begin
      stallCnt_d = stallCnt_q + {{(CNT_W-1){1'b0}}, stall};
      flushCnt_d = flushCnt_q + {{(CNT_W-1){1'b0}}, flush};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stallCnt_q <= '0;
         flushCnt_q <= '0;
      end else begin
         stallCnt_q <= stallCnt_d;
         flushCnt_q <= flushCnt_d;
      end
   end

   assign bus.STALL_CYCLES = stallCnt_q;
   assign bus.FLUSH_COUNT  = flushCnt_q;
`else
   logic [CNT_W-1:0] zeroCnt;

   assign zeroCnt          = '0;
   assign bus.STALL_CYCLES = zeroCnt;
   assign bus.FLUSH_COUNT  = zeroCnt;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a per-cycle stall-budget model plus
// literal expectations for each hazard scenario, reset and the counters.
module tb_hazard_stall_unit;

   localparam int REG_BITS = 5;
   localparam int CNT_W    = 32;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk;
   logic rst_n;

   hazard_stall_unit_if #(.REG_BITS(REG_BITS), .CNT_W(CNT_W)) bus ();

   hazard_stall_unit #(.REG_BITS(REG_BITS), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passCount  = 0;
   int checkCount = 0;

   task automatic checkValue(input string name, input longint actual, input longint expected);
      checkCount++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: how many more cycles the pipeline must stay frozen, plus event tallies.
   bit     modelValid = 1'b0;
   int     stallsOwed = 0;
   int     nextOwed   = 0;
   longint stallTally = 0;
   longint flushTally = 0;
   longint nextStall  = 0;
   longint nextFlush  = 0;

   function automatic bit readsReg(input logic [REG_BITS-1:0] r);
      return (r != 0) && ((r == bus.IF_ID_RS) || (bus.IF_ID_USES_RT && (r == bus.IF_ID_RT)));
   endfunction

   function automatic int hazardNeed();
      int n = 0;
      if (bus.ID_EX_MEMREAD && readsReg(bus.ID_EX_DEST)) n = bus.IF_ID_BRANCH ? 2 : 1;
      if (bus.IF_ID_BRANCH && bus.ID_EX_REGWRITE && !bus.ID_EX_MEMREAD
          && readsReg(bus.ID_EX_DEST) && n < 1) n = 1;
      if (bus.IF_ID_BRANCH && bus.EX_MEM_MEMREAD && readsReg(bus.EX_MEM_RD) && n < 1) n = 1;
      return n;
   endfunction

   always @(negedge clk) begin
      if (modelValid) begin
         bit expStall;
         bit expFlush;
         int need;
         need     = hazardNeed();
         expStall = rst_n && ((stallsOwed > 0) || (need > 0));
         expFlush = rst_n && !expStall && bus.BRANCH_TAKEN;
         checkValue("model PC_WRITE", bus.PC_WRITE, !expStall);
         checkValue("model IF_ID_WRITE", bus.IF_ID_WRITE, !expStall);
         checkValue("model ID_EX_BUBBLE", bus.ID_EX_BUBBLE, expStall);
         checkValue("model IF_ID_FLUSH", bus.IF_ID_FLUSH, expFlush);
         checkValue("model STALL_CYCLES", bus.STALL_CYCLES, PERF ? stallTally : 0);
         checkValue("model FLUSH_COUNT", bus.FLUSH_COUNT, PERF ? flushTally : 0);
         if (!rst_n) begin
            nextOwed  = 0;
            nextStall = 0;
            nextFlush = 0;
         end else begin
            nextOwed  = (stallsOwed > 0) ? stallsOwed - 1 : ((need > 0) ? need - 1 : 0);
            nextStall = (stallTally + (expStall ? 1 : 0)) % (64'd1 << CNT_W);
            nextFlush = (flushTally + (expFlush ? 1 : 0)) % (64'd1 << CNT_W);
         end
      end
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         modelValid = 1'b1;
         stallsOwed = 0;
         stallTally = 0;
         flushTally = 0;
      end else if (modelValid) begin
         stallsOwed = nextOwed;
         stallTally = nextStall;
         flushTally = nextFlush;
      end
   end

   task automatic applyStimulus(
      input bit rstN, input bit br, input bit taken,
      input int rs, input int rt, input bit usesRt,
      input bit exLoad, input bit exWrite, input int exDest,
      input bit memLoad, input int memRd);
      @(posedge clk);
      #1;
      rst_n              = rstN;
      bus.IF_ID_BRANCH   = br;
      bus.BRANCH_TAKEN   = taken;
      bus.IF_ID_RS       = REG_BITS'(rs);
      bus.IF_ID_RT       = REG_BITS'(rt);
      bus.IF_ID_USES_RT  = usesRt;
      bus.ID_EX_MEMREAD  = exLoad;
      bus.ID_EX_REGWRITE = exWrite;
      bus.ID_EX_DEST     = REG_BITS'(exDest);
      bus.EX_MEM_MEMREAD = memLoad;
      bus.EX_MEM_RD      = REG_BITS'(memRd);
   endtask

   task automatic applyIdle(input bit taken);
      applyStimulus(1, 0, taken, 1, 2, 1, 0, 0, 0, 0, 0);
   endtask

   // Literal expectation for one cycle: stall=1 means the pipeline is frozen.
   task automatic checkOutput(input string name, input bit stall, input bit flush);
      @(negedge clk);
      #1;
      checkValue({name, " PC_WRITE"}, bus.PC_WRITE, !stall);
      checkValue({name, " IF_ID_WRITE"}, bus.IF_ID_WRITE, !stall);
      checkValue({name, " ID_EX_BUBBLE"}, bus.ID_EX_BUBBLE, stall);
      checkValue({name, " IF_ID_FLUSH"}, bus.IF_ID_FLUSH, flush);
   endtask

   task automatic checkCounters(input string name, input longint stalls, input longint flushes);
      checkValue({name, " STALL_CYCLES"}, bus.STALL_CYCLES, PERF ? stalls : 0);
      checkValue({name, " FLUSH_COUNT"}, bus.FLUSH_COUNT, PERF ? flushes : 0);
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.IF_ID_BRANCH   = 1'b1;
      bus.BRANCH_TAKEN   = 1'b1;
      bus.IF_ID_RS       = 5'd8;
      bus.IF_ID_RT       = 5'd0;
      bus.IF_ID_USES_RT  = 1'b0;
      bus.ID_EX_MEMREAD  = 1'b1;
      bus.ID_EX_REGWRITE = 1'b1;
      bus.ID_EX_DEST     = 5'd8;
      bus.EX_MEM_MEMREAD = 1'b0;
      bus.EX_MEM_RD      = 5'd0;

      // Reset overrides a live hazard and a taken branch.
      checkOutput("reset", 0, 0);
      applyStimulus(0, 1, 1, 8, 0, 0, 1, 1, 8, 0, 0);
      checkOutput("reset held", 0, 0);
      checkCounters("after reset", 0, 0);
      applyIdle(0);
      checkOutput("idle", 0, 0);

      // Load-use: one bubble, then the load has moved to MEM.
      applyStimulus(1, 0, 0, 8, 3, 1, 1, 1, 8, 0, 0);
      checkOutput("load-use", 1, 0);
      applyStimulus(1, 0, 0, 8, 3, 1, 0, 1, 4, 1, 8);
      checkOutput("load-use resolved", 0, 0);

      // Branch after load on rt: two bubbles, taken ignored in HOLD.
      applyStimulus(1, 1, 0, 3, 9, 1, 1, 1, 9, 0, 0);
      checkOutput("br-load c1", 1, 0);
      applyStimulus(1, 1, 1, 3, 9, 1, 0, 0, 0, 1, 9);
      checkOutput("br-load hold", 1, 0);
      applyStimulus(1, 1, 1, 3, 9, 1, 0, 0, 0, 0, 0);
      checkOutput("br-load taken", 0, 1);
      applyIdle(0);
      checkOutput("after flush", 0, 0);
      checkCounters("after br-load", 3, 1);

      // Branch after ALU op, then branch after load in MEM: one bubble each.
      applyStimulus(1, 1, 0, 10, 2, 1, 0, 1, 10, 0, 0);
      checkOutput("br-alu", 1, 0);
      applyStimulus(1, 1, 0, 10, 2, 1, 0, 0, 0, 0, 0);
      checkOutput("br-alu resolved", 0, 0);
      applyStimulus(1, 1, 0, 10, 2, 1, 0, 0, 0, 1, 10);
      checkOutput("br-memload", 1, 0);
      applyStimulus(1, 1, 0, 10, 2, 1, 0, 0, 0, 0, 0);
      checkOutput("br-memload resolved", 0, 0);

      // Register 0 and unused rt never stall; ALU op in EX without a branch is forwarded.
      applyStimulus(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
      checkOutput("dest r0", 0, 0);
      applyStimulus(1, 0, 0, 4, 8, 0, 1, 1, 8, 0, 0);
      checkOutput("rt unused", 0, 0);
      applyStimulus(1, 0, 0, 10, 2, 1, 0, 1, 10, 0, 0);
      checkOutput("alu no branch", 0, 0);

      // rs and rt both match: still one bubble.
      applyStimulus(1, 0, 0, 8, 8, 1, 1, 1, 8, 0, 0);
      checkOutput("double match", 1, 0);
      applyIdle(0);
      checkOutput("double resolved", 0, 0);

      // Flush lasts one cycle; a taken branch during a RUN stall is ignored too.
      applyIdle(1);
      checkOutput("flush", 0, 1);
      applyIdle(0);
      checkOutput("flush drop", 0, 0);
      applyStimulus(1, 0, 1, 8, 3, 1, 1, 1, 8, 0, 0);
      checkOutput("taken in stall", 1, 0);

      // Branch with both loads ahead: maximum need is two.
      applyStimulus(1, 1, 0, 5, 6, 1, 1, 1, 5, 1, 6);
      checkOutput("max need c1", 1, 0);
      applyIdle(0);
      checkOutput("max need hold", 1, 0);
      applyIdle(0);
      checkOutput("max need done", 0, 0);

      // Reset during HOLD aborts the second bubble and clears the counters.
      applyStimulus(1, 1, 0, 3, 9, 1, 1, 1, 9, 0, 0);
      checkOutput("pre-reset stall", 1, 0);
      applyStimulus(0, 1, 1, 3, 9, 1, 1, 1, 9, 0, 0);
      checkOutput("reset in hold", 0, 0);
      applyIdle(0);
      checkOutput("run after reset", 0, 0);
      checkCounters("after hold reset", 0, 0);

      applyIdle(0);
      @(negedge clk);
      #2;
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
